// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32 main control FSM.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_MUL
    } state_e;

    typedef enum logic [2:0] {
        K_ILLEGAL,
        K_R,
        K_I,
        K_LOAD,
        K_STORE,
        K_BRANCH
    } opk_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    function automatic opk_e op_kind(input logic [6:0] op);
        case (op)
            OPC_R:      return K_R;
            OPC_I:      return K_I;
            OPC_LOAD:   return K_LOAD;
            OPC_STORE:  return K_STORE;
            OPC_BRANCH: return K_BRANCH;
            default:    return K_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction handshake, memory-ready and datapath control bundle for multicycle_ctrl.
interface multicycle_ctrl_if #(
    parameter int OP_W    = 7,
    parameter int ALUOP_W = 2
);
    logic               instr_valid_i;
    logic               instr_ready_o;
    logic [OP_W-1:0]    Op_i;
    logic [6:0]         Funct7_i;
    logic               mem_ready_i;
    logic               IRWrite_o;
    logic               ALUSrc_o;
    logic [ALUOP_W-1:0] ALUOp_o;
    logic               MemRead_o;
    logic               MemWrite_o;
    logic               MemtoReg_o;
    logic               RegWrite_o;
    logic               Branch_o;
    logic               PCWrite_o;
    logic               busy_o;
    logic               err_o;

    modport slave (
        input  instr_valid_i, Op_i, Funct7_i, mem_ready_i,
        output instr_ready_o, IRWrite_o, ALUSrc_o, ALUOp_o, MemRead_o, MemWrite_o,
               MemtoReg_o, RegWrite_o, Branch_o, PCWrite_o, busy_o, err_o
    );

    modport master (
        output instr_valid_i, Op_i, Funct7_i, mem_ready_i,
        input  instr_ready_o, IRWrite_o, ALUSrc_o, ALUOp_o, MemRead_o, MemWrite_o,
               MemtoReg_o, RegWrite_o, Branch_o, PCWrite_o, busy_o, err_o
    );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// ctrl_wait_timer: clearable, enabled up-counter that saturates at all-ones and flags a terminal count.
module ctrl_wait_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] tc_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == tc_val_i);
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 main control FSM (IDLE/DECODE/EXEC/MEM/WB) with memory wait-state timeout.
// Define MULTICYCLE_CTRL_MUL_EN to add the MUL state for funct7=0000001 R-type instructions.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OP_W        = 7,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int MUL_LATENCY = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    multicycle_ctrl_if.slave bus
);
`ifdef MULTICYCLE_CTRL_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    localparam int TMAX  = (MEM_TIMEOUT > MUL_LATENCY) ? MEM_TIMEOUT : MUL_LATENCY;
    localparam int CNT_W = $clog2(TMAX + 1);

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [6:0]      f7_q, f7_d;
    opk_e            kind;
    logic            is_mul;

    logic             tmr_clr, tmr_tc;
    logic [CNT_W-1:0] tmr_cnt, tmr_tc_val;

    logic       ready, irwrite, alusrc, memread, memwrite, memtoreg;
    logic       regwrite, branch, pcwrite, busy, err;
    logic [1:0] aluop;

    assign kind   = op_kind(7'(op_q));
    assign is_mul = MulEn && (kind == K_R) && (f7_q == F7_MULDIV);

    // One timer serves both MEM wait counting and MUL occupancy; it idles at zero elsewhere.
    assign tmr_clr    = (state_q != S_MEM) && (state_q != S_MUL);
    assign tmr_tc_val = (state_q == S_MUL) ? CNT_W'(MUL_LATENCY - 1) : CNT_W'(MEM_TIMEOUT - 1);

    ctrl_wait_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (tmr_clr),
        .en_i     (!tmr_clr),
        .tc_val_i (tmr_tc_val),
        .cnt_o    (tmr_cnt),
        .tc_o     (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        f7_d     = f7_q;
        ready    = 1'b0;
        irwrite  = 1'b0;
        alusrc   = 1'b0;
        aluop    = ALUOP_ADD;
        memread  = 1'b0;
        memwrite = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        branch   = 1'b0;
        pcwrite  = 1'b0;
        busy     = 1'b1;
        err      = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (bus.instr_valid_i) begin
                    irwrite = 1'b1;
                    op_d    = bus.Op_i;
                    f7_d    = bus.Funct7_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (kind == K_ILLEGAL) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (kind)
                    K_R: begin
                        aluop   = ALUOP_RTYPE;
                        state_d = is_mul ? S_MUL : S_WB;
                    end
                    K_I: begin
                        alusrc  = 1'b1;
                        aluop   = ALUOP_ITYPE;
                        state_d = S_WB;
                    end
                    K_LOAD, K_STORE: begin
                        alusrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    K_BRANCH: begin
                        aluop   = ALUOP_SUB;
                        branch  = 1'b1;
                        pcwrite = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_MEM: begin
                alusrc   = 1'b1;
                memread  = (kind == K_LOAD);
                memwrite = (kind == K_STORE);
                // A ready on the final allowed cycle still completes the access.
                if (bus.mem_ready_i) begin
                    if (kind == K_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pcwrite = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tmr_tc) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                pcwrite  = 1'b1;
                memtoreg = (kind == K_LOAD);
                case (kind)
                    K_R: aluop = ALUOP_RTYPE;
                    K_I: begin
                        alusrc = 1'b1;
                        aluop  = ALUOP_ITYPE;
                    end
                    K_LOAD:  alusrc = 1'b1;
                    default: ;
                endcase
                state_d = S_IDLE;
            end
`ifdef MULTICYCLE_CTRL_MUL_EN
            S_MUL: begin
                aluop = ALUOP_RTYPE;
                if (tmr_tc) begin
                    state_d = S_WB;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            f7_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            f7_q    <= f7_d;
        end
    end

    assign bus.instr_ready_o = ready;
    assign bus.IRWrite_o     = irwrite;
    assign bus.ALUSrc_o      = alusrc;
    assign bus.ALUOp_o       = ALUOP_W'(aluop);
    assign bus.MemRead_o     = memread;
    assign bus.MemWrite_o    = memwrite;
    assign bus.MemtoReg_o    = memtoreg;
    assign bus.RegWrite_o    = regwrite;
    assign bus.Branch_o      = branch;
    assign bus.PCWrite_o     = pcwrite;
    assign bus.busy_o        = busy;
    assign bus.err_o         = err;

    logic unused_cnt;
    assign unused_cnt = ^tmr_cnt;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: per-instruction activity summaries vs. a spec-level model.
module tb_multicycle_ctrl;
    localparam int OP_W        = 7;
    localparam int ALUOP_W     = 2;
    localparam int MEM_TIMEOUT = 16;
    localparam int MUL_LATENCY = 4;
`ifdef MULTICYCLE_CTRL_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    typedef struct {
        int err, lat, regw, pcw, mrd, mwr, m2r, br, irw, exsrc, exop;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) bus ();

    multicycle_ctrl #(
        .OP_W(OP_W), .ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .MUL_LATENCY(MUL_LATENCY)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    rec_t exp_q[$];
    int   n_chk = 0, n_fail = 0;
    int   n_issued = 0, n_start = 0;
    int   cur_w = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Expected whole-instruction activity derived from the opcode rules and the memory wait count.
    function automatic rec_t model(input logic [6:0] op, input logic [6:0] f7, input int w);
        rec_t r = '{default: 0};
        r.irw = 1;
        case (op)
            7'b0110011: begin
                r.lat = (MUL_ON && f7 == 7'b0000001) ? 4 + MUL_LATENCY : 4;
                r.regw = 1; r.pcw = 1; r.exop = 2;
            end
            7'b0010011: begin
                r.lat = 4; r.regw = 1; r.pcw = 1; r.exsrc = 1; r.exop = 3;
            end
            7'b0000011: begin
                r.exsrc = 1;
                if (w < MEM_TIMEOUT) begin
                    r.lat = 5 + w; r.mrd = w + 1; r.regw = 1; r.pcw = 1; r.m2r = 1;
                end else begin
                    r.lat = 3 + MEM_TIMEOUT; r.mrd = MEM_TIMEOUT; r.err = 1;
                end
            end
            7'b0100011: begin
                r.exsrc = 1;
                if (w < MEM_TIMEOUT) begin
                    r.lat = 4 + w; r.mwr = w + 1; r.pcw = 1;
                end else begin
                    r.lat = 3 + MEM_TIMEOUT; r.mwr = MEM_TIMEOUT; r.err = 1;
                end
            end
            7'b1100011: begin
                r.lat = 3; r.br = 1; r.pcw = 1; r.exop = 1;
            end
            default: begin
                r.lat = 2; r.err = 1;
            end
        endcase
        return r;
    endfunction

    task automatic chk_idle_outputs(input string p);
        chk({p, "_ready"},    int'(bus.instr_ready_o), 1);
        chk({p, "_irwrite"},  int'(bus.IRWrite_o), 0);
        chk({p, "_alusrc"},   int'(bus.ALUSrc_o), 0);
        chk({p, "_aluop"},    int'(bus.ALUOp_o), 0);
        chk({p, "_memread"},  int'(bus.MemRead_o), 0);
        chk({p, "_memwrite"}, int'(bus.MemWrite_o), 0);
        chk({p, "_memtoreg"}, int'(bus.MemtoReg_o), 0);
        chk({p, "_regwrite"}, int'(bus.RegWrite_o), 0);
        chk({p, "_branch"},   int'(bus.Branch_o), 0);
        chk({p, "_pcwrite"},  int'(bus.PCWrite_o), 0);
        chk({p, "_busy"},     int'(bus.busy_o), 0);
        chk({p, "_err"},      int'(bus.err_o), 0);
    endtask

    // Memory responder: raises mem_ready_i on the cur_w-th access cycle (0-based).
    initial begin
        int mcnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.MemRead_o || bus.MemWrite_o)) begin
                bus.mem_ready_i = (mcnt == cur_w);
                mcnt++;
            end else begin
                bus.mem_ready_i = 1'b0;
                mcnt = 0;
            end
        end
    end

    // Monitor: accumulates activity from accept until the FSM returns to IDLE, then scores it.
    initial begin
        bit   in_instr = 0;
        int   cyc = 0;
        rec_t cur, e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                in_instr = 0;
                continue;
            end
            if (in_instr) begin
                if (bus.instr_ready_o) begin
                    cur.lat = cyc;
                    in_instr = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_instr", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("latency",   cur.lat,   e.lat);
                        chk("err",       cur.err,   e.err);
                        chk("regwrite",  cur.regw,  e.regw);
                        chk("pcwrite",   cur.pcw,   e.pcw);
                        chk("memread",   cur.mrd,   e.mrd);
                        chk("memwrite",  cur.mwr,   e.mwr);
                        chk("memtoreg",  cur.m2r,   e.m2r);
                        chk("branch",    cur.br,    e.br);
                        chk("irwrite",   cur.irw,   e.irw);
                        chk("exec_src",  cur.exsrc, e.exsrc);
                        chk("exec_aluop", cur.exop, e.exop);
                    end
                end else begin
                    cur.err  += int'(bus.err_o);
                    cur.regw += int'(bus.RegWrite_o);
                    cur.pcw  += int'(bus.PCWrite_o);
                    cur.mrd  += int'(bus.MemRead_o);
                    cur.mwr  += int'(bus.MemWrite_o);
                    cur.m2r  += int'(bus.MemtoReg_o);
                    cur.br   += int'(bus.Branch_o);
                    cur.irw  += int'(bus.IRWrite_o);
                    if (cyc == 2) begin
                        cur.exsrc = int'(bus.ALUSrc_o);
                        cur.exop  = int'(bus.ALUOp_o);
                    end
                    cyc++;
                end
            end
            if (!in_instr && bus.IRWrite_o) begin
                cur = '{default: 0};
                cur.irw = 1;
                cyc = 1;
                in_instr = 1;
                n_start++;
            end
        end
    end

    task automatic issue(input logic [6:0] op, input logic [6:0] f7, input int w, input bit hold);
        int n = 0;
        cur_w = w;
        exp_q.push_back(model(op, f7, w));
        n_issued++;
        bus.Op_i = op;
        bus.Funct7_i = f7;
        bus.instr_valid_i = 1'b1;
        while (!bus.instr_ready_o && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_bound", int'(n < 200), 1);
        @(posedge clk); #1;
        if (hold) begin
            @(posedge clk); #1;
        end
        bus.instr_valid_i = 1'b0;
        bus.Op_i = 7'($urandom);
        bus.Funct7_i = 7'($urandom);
        n = 0;
        while (!bus.instr_ready_o && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_bound", int'(n < 200), 1);
    endtask

    function automatic logic [6:0] rand_illegal();
        logic [6:0] o;
        do o = 7'($urandom);
        while (o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 ||
               o == 7'b0100011 || o == 7'b1100011);
        return o;
    endfunction

    initial begin
        logic [6:0] ops [5];
        int n;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011;
        bus.instr_valid_i = 1'b0;
        bus.Op_i = '0;
        bus.Funct7_i = '0;
        bus.mem_ready_i = 1'b0;

        #12;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed: R, LOAD w=3, STORE timeout, illegal with held valid, BRANCH, MUL-capable R.
        issue(7'b0110011, 7'b0000000, 0, 0);
        issue(7'b0000011, 7'b0000000, 3, 0);
        issue(7'b0100011, 7'b0000000, 1000, 0);
        issue(7'b1111111, 7'b0000000, 0, 1);
        issue(7'b1100011, 7'b0000000, 0, 1);
        issue(7'b0110011, 7'b0000001, 0, 0);
        issue(7'b0000011, 7'b0000000, MEM_TIMEOUT - 1, 0);
        issue(7'b0100011, 7'b0000000, MEM_TIMEOUT, 0);

        // Reset in the middle of a LOAD access aborts it.
        cur_w = 1000;
        bus.Op_i = 7'b0000011;
        bus.instr_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid_i = 1'b0;
        n_issued++;
        n = 0;
        while (!bus.MemRead_o && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("abort_memread_seen", int'(bus.MemRead_o), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            logic [6:0] op, f7;
            int w, sel;
            sel = $urandom_range(0, 6);
            op = (sel >= 5) ? rand_illegal() : ops[sel];
            f7 = ($urandom_range(0, 3) == 0) ? 7'b0000001 : 7'($urandom);
            case ($urandom_range(0, 7))
                0: w = MEM_TIMEOUT - 1;
                1: w = MEM_TIMEOUT + $urandom_range(0, 5);
                default: w = $urandom_range(0, 4);
            endcase
            issue(op, f7, w, 1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("accept_count", n_start, n_issued);
        chk_idle_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
